// File: rtl/updown_counter_pkg.sv
// Purpose: shared constants and helpers for the parametrised up/down counter.
// Latency: n/a (package only).
// Backpressure: n/a.
package updown_counter_pkg;

    // Direction encoding as seen on status/dir_q.
    localparam bit DIR_UP   = 1'b0;
    localparam bit DIR_DOWN = 1'b1;

    // Boundary behaviour selected by the SATURATE parameter.
    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Limit a value to the counter's terminal value.
    function automatic int unsigned clamp_max(input int unsigned val, input int unsigned max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/dir_change_det.sv
// Purpose: registers the requested direction and flags a pending direction change.
// Latency: dir_q follows status one clk edge later; dir_chg is combinational.
// Backpressure: none.
//   Ports: clk, rst (async active-high), status (requested direction),
//          dir_q (direction in effect), dir_chg (status differs from dir_q).
module dir_change_det
    import updown_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic status,
    output logic dir_q,
    output logic dir_chg
);

    // Every rule that touches the direction (load or change) lands on status,
    // and when neither applies status already equals dir_q, so a plain
    // register is exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= status;
        end
    end

    assign dir_chg = (status != dir_q);

endmodule

// File: rtl/updown_counter_param.sv
// Purpose: up/down counter with modulus, load, enable, wrap/saturate, reload on direction change.
// Latency: count/ovf/dir_q update one clk edge after inputs; tc is combinational.
// Backpressure: none; en qualifies steps, load and direction change take priority.
//   Ports: clk, rst (async active-high), en, status (0 up / 1 down), load, load_val,
//          count, tc (next enabled step crosses boundary), ovf (boundary pulse), dir_q.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int MAX_VAL       = 2**WIDTH - 1,
    parameter bit SATURATE      = MODE_WRAP,
    parameter bit RELOAD_ON_DIR = 1'b1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             status,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             dir_q
);

    if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL >= 2**WIDTH) begin : g_bad_params
        $error("updown_counter_param: need WIDTH>=2 and 1<=MAX_VAL<2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             dir_chg;
    logic             at_bound;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_d;
    logic             ovf_d;

    dir_change_det u_dir (
        .clk     (clk),
        .rst     (rst),
        .status  (status),
        .dir_q   (dir_q),
        .dir_chg (dir_chg)
    );

    assign load_clamped = WIDTH'(clamp_max(32'(load_val), 32'(MAX_VAL)));

    // Boundary for the direction currently in effect (never raw status).
    assign at_bound = (dir_q == DIR_DOWN) ? (count == '0) : (count == MAX_W);

    // A step only happens when neither load nor a direction change pre-empts it.
    assign tc = en & ~load & ~dir_chg & at_bound;

    always_comb begin
        count_d = count;
        ovf_d   = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (dir_chg) begin
            if (RELOAD_ON_DIR) begin
                count_d = (status == DIR_DOWN) ? MAX_W : '0;
            end
        end else if (en) begin
            if (at_bound) begin
                ovf_d = 1'b1;
                if (SATURATE == MODE_WRAP) begin
                    count_d = (dir_q == DIR_DOWN) ? MAX_W : '0;
                end
            end else if (dir_q == DIR_DOWN) begin
                count_d = count - WIDTH'(1);
            end else begin
                count_d = count + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            ovf   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

    localparam int NI = 3;
    // Instance 0: MAX 9 wrap; 1: MAX 9 saturate; 2: default parameters (MAX 15 wrap).
    localparam int MAXV [NI] = '{9, 9, 15};
    localparam bit SATV [NI] = '{1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       status = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] cnt_o [NI];
    logic       tc_o  [NI];
    logic       ovf_o [NI];
    logic       dir_o [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: plain integers per instance.
    int m_cnt [NI];
    int m_ovf [NI];
    int m_dir [NI];

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RELOAD_ON_DIR(1'b1)) dut_wrap9 (
        .clk(clk), .rst(rst), .en(en), .status(status), .load(load), .load_val(load_val),
        .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .dir_q(dir_o[0]));

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .RELOAD_ON_DIR(1'b1)) dut_sat9 (
        .clk(clk), .rst(rst), .en(en), .status(status), .load(load), .load_val(load_val),
        .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .dir_q(dir_o[1]));

    updown_counter_param dut_dflt (
        .clk(clk), .rst(rst), .en(en), .status(status), .load(load), .load_val(load_val),
        .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]), .dir_q(dir_o[2]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 0;
            m_dir[k] = 0;
        end
    endfunction

    function automatic int model_tc(input int k);
        int bound;
        bound = (m_dir[k] != 0) ? 0 : MAXV[k];
        return (en && !load && (int'(status) == m_dir[k]) && m_cnt[k] == bound) ? 1 : 0;
    endfunction

    // Counter behaviour expressed directly as arithmetic on the count range 0..max.
    function automatic void model_edge();
        for (int k = 0; k < NI; k++) begin
            m_ovf[k] = 0;
            if (load) begin
                m_cnt[k] = (int'(load_val) > MAXV[k]) ? MAXV[k] : int'(load_val);
                m_dir[k] = int'(status);
            end else if (int'(status) != m_dir[k]) begin
                m_dir[k] = int'(status);
                m_cnt[k] = status ? MAXV[k] : 0;
            end else if (en) begin
                int nxt;
                nxt = m_cnt[k] + (m_dir[k] != 0 ? -1 : 1);
                if (nxt < 0 || nxt > MAXV[k]) begin
                    m_ovf[k] = 1;
                    if (!SATV[k]) m_cnt[k] = (nxt < 0) ? MAXV[k] : 0;
                end else begin
                    m_cnt[k] = nxt;
                end
            end
        end
    endfunction

    function automatic string tg(input string what, input int k);
        return $sformatf("%s[%0d]", what, k);
    endfunction

    // Inputs are already driven; check tc, clock once, then check registered state.
    task automatic cycle();
        #1;
        for (int k = 0; k < NI; k++) check(tg("tc", k), 32'(tc_o[k]), 32'(model_tc(k)));
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < NI; k++) begin
            check(tg("count", k), 32'(cnt_o[k]), 32'(m_cnt[k]));
            check(tg("ovf", k),   32'(ovf_o[k]), 32'(m_ovf[k]));
            check(tg("dir_q", k), 32'(dir_o[k]), 32'(m_dir[k]));
        end
    endtask

    task automatic drive(input logic e, input logic s, input logic l, input logic [3:0] lv);
        en = e; status = s; load = l; load_val = lv;
    endtask

    initial begin
        model_reset();
        #12;
        for (int k = 0; k < NI; k++) begin
            check(tg("rst_count", k), 32'(cnt_o[k]), 32'd0);
            check(tg("rst_ovf", k),   32'(ovf_o[k]), 32'd0);
            check(tg("rst_dir", k),   32'(dir_o[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Count up 12 edges: MAX 9 instance goes 1..9,0,1,2.
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 12; i++) cycle();
        check("wrap9_after12", 32'(cnt_o[0]), 32'd2);
        check("sat9_after12",  32'(cnt_o[1]), 32'd9);

        // Down from 2 with saturation: 1,0,0,0 and ovf on blocked steps.
        drive(1'b0, 1'b1, 1'b1, 4'd2);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) cycle();
        check("sat9_hold0",  32'(cnt_o[1]), 32'd0);
        check("sat9_ovf",    32'(ovf_o[1]), 32'd1);

        // Load 5 counting up, then raise status: reload MAX, count down, fall -> 0.
        drive(1'b1, 1'b0, 1'b1, 4'd5);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        cycle();
        check("reload_down9", 32'(cnt_o[0]), 32'd9);
        cycle();
        cycle();
        check("down_to7", 32'(cnt_o[0]), 32'd7);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        cycle();
        check("reload_up0", 32'(cnt_o[0]), 32'd0);

        // Load clamping and load beating a simultaneous direction toggle.
        drive(1'b0, 1'b0, 1'b1, 4'd13);
        cycle();
        check("clamp13_to9", 32'(cnt_o[0]), 32'd9);
        check("load13_dflt", 32'(cnt_o[2]), 32'd13);
        drive(1'b1, 1'b1, 1'b1, 4'd4);
        cycle();
        check("load_wins", 32'(cnt_o[0]), 32'd4);
        check("load_dir",  32'(dir_o[0]), 32'd1);

        // Asynchronous reset between edges at count 6.
        drive(1'b1, 1'b0, 1'b1, 4'd6);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < NI; k++) begin
            check(tg("async_rst_count", k), 32'(cnt_o[k]), 32'd0);
            check(tg("async_rst_ovf", k),   32'(ovf_o[k]), 32'd0);
        end
        #1 rst = 1'b0;
        cycle();

        // Enable toggling on the default instance through its 15 -> 0 wrap.
        drive(1'b0, 1'b0, 1'b1, 4'd13);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1'(i % 2), 1'b0, 1'b0, 4'd0);
            cycle();
        end
        check("dflt_wrap", 32'(cnt_o[2]), 32'd1);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic s;
            s = status;
            if ($urandom_range(0, 7) == 0) s = ~s;
            drive(1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) == 0) begin
                #3 rst = 1'b1;
                #1 model_reset();
                #1 rst = 1'b0;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
